// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the controller state encoding and the step counter width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CALC,
    DONE
  } state_e;

  // Step counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w < 3) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/add_sub_w.sv
// Combinational ripple adder/subtractor for the partial product.
// sub=1 inverts b and injects a carry, giving a - b.
module add_sub_w #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s
);

  logic [W-1:0] bx;
  logic         cy;

  assign bx = b ^ {W{sub}};

  always_comb begin
    cy = sub;
    s  = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ bx[i] ^ cy;
      cy   = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
  end

endmodule

// File: rtl/mult_shift_add.sv
// Sequential shift-add multiplier: one multiplier bit per cycle,
// signed or unsigned, product in {A,B} with extension bit X.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Load_B,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   Din,
  output logic               X,
  output logic [WIDTH-1:0]   A_out,
  output logic [WIDTH-1:0]   B_out,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last;
  logic [WIDTH:0]   ext_s;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic             sub;

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign ext_s  = mode_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
  assign addend = b_q[0] ? ext_s : '0;
  // The MSB of a signed multiplier carries negative weight.
  assign sub    = b_q[0] & mode_q & last;

  add_sub_w #(
    .W(WIDTH + 1)
  ) u_add (
    .a  ({x_q, a_q}),
    .b  (addend),
    .sub(sub),
    .s  (sum)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Load_B) begin
          b_d = Din;
        end else if (Run) begin
          s_d     = Din;
          mode_d  = Signed_Mode;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        x_d     = 1'b0;
        a_d     = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        a_d = sum[WIDTH:1];
        b_d = {sum[0], b_q[WIDTH-1:1]};
        x_d = mode_q & sum[WIDTH];
        if (last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (Load_B) begin
          b_d = Din;
        end else if (!Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign X       = x_q;
  assign A_out   = a_q;
  assign B_out   = b_q;
  assign Product = {a_q, b_q};
  assign Busy    = (state_q == CLEAR) || (state_q == CALC);
  assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_mult_shift_add.sv
// Randomised and directed bench for mult_shift_add against an
// arithmetic reference model of the multiply/handshake behaviour.
module tb_mult_shift_add;

  localparam int W = 8;

  logic          Clk = 1'b0;
  logic          Reset, Run, Load_B, Signed_Mode;
  logic [W-1:0]  Din;
  logic          X, Busy, Done;
  logic [W-1:0]  A_out, B_out;
  logic [2*W-1:0] Product;

  logic          Reset16, Run16, Load16, Sm16;
  logic [15:0]   Din16, A16, B16;
  logic [31:0]   Product16;
  logic          X16, Busy16, Done16;

  always #5 Clk = ~Clk;

  mult_shift_add #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Load_B(Load_B),
    .Signed_Mode(Signed_Mode), .Din(Din), .X(X),
    .A_out(A_out), .B_out(B_out), .Product(Product),
    .Busy(Busy), .Done(Done)
  );

  mult_shift_add #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset16), .Run(Run16), .Load_B(Load16),
    .Signed_Mode(Sm16), .Din(Din16), .X(X16),
    .A_out(A16), .B_out(B16), .Product(Product16),
    .Busy(Busy16), .Done(Done16)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mul8(input logic [7:0] b,
                                       input logic [7:0] s,
                                       input logic sm);
    logic signed [15:0] sb, ss;
    if (sm) begin
      sb = $signed(b);
      ss = $signed(s);
      return sb * ss;
    end
    return {8'h00, b} * {8'h00, s};
  endfunction

  // Reference model: operation takes WIDTH+1 busy cycles, then Done.
  bit          m_busy = 0, m_done = 0, chk_en = 0;
  int          m_left = 0;
  logic [7:0]  m_hi = 0, m_lo = 0, m_s = 0;
  logic        m_sm = 0, m_x = 0;
  logic [15:0] mp;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_busy = 0; m_done = 0; m_left = 0;
      m_hi = 0; m_lo = 0; m_x = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        mp = mul8(m_lo, m_s, m_sm);
        m_hi = mp[15:8];
        m_lo = mp[7:0];
        m_x = m_sm & mp[15];
        m_busy = 0;
        m_done = 1;
      end
    end else if (m_done) begin
      if (Load_B) m_lo = Din;
      else if (!Run) m_done = 0;
    end else begin
      if (Load_B) m_lo = Din;
      else if (Run) begin
        m_s = Din;
        m_sm = Signed_Mode;
        m_left = W + 1;
        m_busy = 1;
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    if (chk_en) begin
      chk("busy", Busy, m_busy);
      chk("done", Done, m_done);
      if (!m_busy) begin
        chk("product", Product, {m_hi, m_lo});
        chk("x", X, m_x);
      end
    end
  end

  task automatic load_b(input logic [7:0] v);
    @(negedge Clk);
    Load_B = 1'b1;
    Din = v;
    @(negedge Clk);
    Load_B = 1'b0;
  endtask

  // Junk on Din/Signed_Mode/Load_B while busy must be ignored.
  task automatic run_op(input logic [7:0] d, input logic sm,
                        output int busy_n, output int lat);
    busy_n = 0;
    lat = 0;
    @(negedge Clk);
    Din = d;
    Signed_Mode = sm;
    Load_B = 1'b0;
    Run = 1'b1;
    do begin
      @(negedge Clk);
      lat++;
      if (Busy) busy_n++;
      if (!Done) begin
        Din = 8'($urandom);
        Signed_Mode = 1'($urandom);
        Load_B = 1'($urandom);
      end
    end while (!Done && lat < 40);
    Load_B = 1'b0;
    chk("run_done", Done, 1'b1);
  endtask

  task automatic release_run(input int hold);
    repeat (hold) @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bn, lat, n;
    Reset = 0; Run = 0; Load_B = 0; Signed_Mode = 0; Din = 0;
    Reset16 = 0; Run16 = 0; Load16 = 0; Sm16 = 0; Din16 = 0;
    repeat (3) @(negedge Clk);
    chk("rst_product", Product, 16'h0000);
    chk("rst_busy", Busy, 1'b0);
    Reset = 1; Reset16 = 1;
    chk_en = 1;

    load_b(8'd7);
    run_op(8'd59, 1'b0, bn, lat);
    chk("p_7x59", Product, 16'h019D);
    chk("x_7x59", X, 1'b0);
    chk("busy_cycles", bn, 9);
    chk("done_edges", lat - 1, 9);
    release_run(0);

    run_op(8'd2, 1'b0, bn, lat);
    repeat (3) @(negedge Clk);
    chk("hold_done", Done, 1'b1);
    chk("p_cont", Product, 16'h013A);
    release_run(0);

    load_b(8'hFF);
    run_op(8'hFF, 1'b1, bn, lat);
    chk("p_ffff_s", Product, 16'h0001);
    chk("x_ffff_s", X, 1'b0);
    release_run(0);
    load_b(8'hFF);
    run_op(8'hFF, 1'b0, bn, lat);
    chk("p_ffff_u", Product, 16'hFE01);
    release_run(0);

    load_b(8'h80);
    run_op(8'h80, 1'b1, bn, lat);
    chk("p_8080_s", Product, 16'h4000);
    release_run(0);
    load_b(8'h80);
    run_op(8'h01, 1'b1, bn, lat);
    chk("p_8001_s", Product, 16'hFF80);
    chk("x_8001_s", X, 1'b1);
    load_b(8'h5A);
    chk("load_in_done", Product, 16'hFF5A);
    release_run(0);

    @(negedge Clk);
    Load_B = 1; Run = 1; Din = 8'h33;
    @(negedge Clk);
    chk("lb_run_busy", Busy, 1'b0);
    chk("lb_run_b", B_out, 8'h33);
    Load_B = 0; Run = 0;
    @(negedge Clk);

    load_b(8'd5);
    @(negedge Clk);
    Din = 8'd9; Signed_Mode = 0; Run = 1;
    repeat (5) @(negedge Clk);
    chk("mid_calc_busy", Busy, 1'b1);
    Reset = 0; Run = 0;
    @(negedge Clk);
    chk("rst_mid_product", Product, 16'h0000);
    chk("rst_mid_busy", Busy, 1'b0);
    chk("rst_mid_done", Done, 1'b0);
    chk("rst_mid_x", X, 1'b0);
    Reset = 1;
    load_b(8'd13);
    run_op(8'd11, 1'b0, bn, lat);
    chk("p_after_rst", Product, 16'd143);
    release_run(0);

    for (int i = 0; i < 30; i++) begin
      if (1'($urandom)) load_b(8'($urandom));
      run_op(8'($urandom), 1'($urandom), bn, lat);
      chk("rand_busy", bn, 9);
      release_run($urandom_range(2, 0));
    end

    @(negedge Clk);
    Load16 = 1; Din16 = 16'h1234;
    @(negedge Clk);
    Load16 = 0; Din16 = 16'h0010; Run16 = 1;
    n = 0; bn = 0;
    do begin
      @(negedge Clk);
      n++;
      if (Busy16) bn++;
    end while (!Done16 && n < 60);
    chk("w16_product", Product16, 32'h00012340);
    chk("w16_busy", bn, 17);
    chk("w16_edges", n - 1, 17);
    Run16 = 0;
    @(negedge Clk);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_shift_add.md
# mult_shift_add

Parametrised sequential shift-add multiplier datapath and controller for the switch/LED lab platform. It multiplies a multiplier held in register B by a multiplicand captured from Din, producing a 2·WIDTH-bit product in {A,B} plus an extension bit X. It supports both two's-complement and unsigned modes. It replaces the fixed 8-bit signed multiplier top level and has a single combinational adder/subtractor sub-module.

## Interface
- WIDTH, 8, operand width; legal range 2..32.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Run  in  1  start request, level-sensitive; must be held until Done and then released.
- Load_B  in  1  load Din into B; honoured only in IDLE or DONE.
- Signed_Mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled together with Din when Run is accepted.
- Din  in  WIDTH  operand input.
- X  out  1  extension/sign bit of the partial product.
- A_out  out  WIDTH  upper product half.
- B_out  out  WIDTH  lower product half / remaining multiplier bits.
- Product  out  2·WIDTH  {A,B}.
- Busy  out  1  high in CLEAR and CALC.
- Done  out  1  high in DONE.

## Operation
- Registers:
  - X (1 bit), A (WIDTH), B (WIDTH).
  - S (WIDTH) holds the latched multiplicand.
  - mode (1 bit) holds the latched Signed_Mode.
  - count (clog2(WIDTH) bits).
- States: IDLE, CLEAR, CALC, DONE.
- IDLE transitions:
  - Load_B=1: B <= Din and stay in IDLE. Load_B has priority over Run in the same cycle, so Run is ignored that cycle.
  - Run=1 and Load_B=0: S <= Din, mode <= Signed_Mode, go to CLEAR.
- CLEAR: X <= 0, A <= 0, count <= 0, go to CALC. B is preserved.
- CALC, one step per cycle:
  - If B[0]=1: sum = ext({X,A}) + ext(S) on WIDTH+1 bits, where ext is sign extension when mode=1 and zero extension otherwise.
  - In signed mode, the step with count=WIDTH-1 subtracts instead: sum = {X,A} + ~ext(S) + 1.
  - If B[0]=0: sum = {X,A}.
  - Register update: A <= sum[WIDTH:1]; B <= {sum[0], B[WIDTH-1:1]}; X <= mode ? sum[WIDTH] : 0.
  - The step with count=WIDTH-1 goes to DONE; otherwise count increments.
- DONE: X, A and B hold their values. Load_B=1 loads B <= Din and stays in DONE. Run=0 goes to IDLE.
- Re-running without Load_B multiplies the current low half B by the new Din. This is continuous multiplication; A and X are cleared in CLEAR.
- Run and Load_B are ignored in CLEAR and CALC. Changes on Din or Signed_Mode during CALC have no effect.
- Product is exact: the signed result is a 2·WIDTH-bit two's-complement value and the unsigned result is a 2·WIDTH-bit unsigned value. Overflow is impossible.

## Timing
- Reset (Reset=0 at a rising edge) has priority over everything in every state, including mid-CALC:
  - state <= IDLE.
  - X, A, B, S, mode and count <= 0.
  - Busy=0, Done=0, Product=0.
- Run sampled high in IDLE at edge k: CLEAR after edge k, CALC after edge k+1, DONE (Done=1) after edge k+WIDTH+1. Total latency is WIDTH+1 cycles; for WIDTH=8, Done rises 9 edges after acceptance.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- If Run is still high in DONE, the block stays in DONE with no retrigger. The next operation requires Run to drop, then one IDLE cycle, then Run high again.

## Structure
- Package mult_pkg holds the state enum typedef (IDLE, CLEAR, CALC, DONE) and a localparam function computing the count width from WIDTH.
- Sub-module add_sub_w (parameter W = WIDTH+1):
  - Inputs: a, b, sub.
  - Output: s.
  - Purely combinational ripple adder with conditional b inversion and carry-in = sub.
- The top level holds the register file, the counter and the FSM. Control and datapath stay in one module aside from add_sub_w.

## Test plan
- WIDTH=8, unsigned, Load_B 8'd7, Run with Din=8'd59 -> after 9 edges Done=1, Product=16'h019D, X=0; Busy high exactly 9 cycles.
- WIDTH=8, B=8'hFF, Din=8'hFF -> signed: Product=16'h0001, X=0; unsigned: Product=16'hFE01.
- WIDTH=8, signed, B=8'h80, Din=8'h80 -> Product=16'h4000; B=8'h80, Din=8'h01 -> Product=16'hFF80, X=1.
- Continuous operation: after 7×59, drop Run, then Run with Din=8'd2 (no Load_B) -> Product=16'h013A (8'h9D×2). Run held through DONE causes no retrigger.
- Reset=0 at the 4th CALC cycle -> next cycle: IDLE, all outputs 0. A subsequent normal multiply is correct. Load_B and Run asserted together in IDLE load B and do not start.
- WIDTH=16, unsigned, B=16'h1234, Din=16'h0010 -> Product=32'h00012340 after 17 edges.
